// File: rtl/pic_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pic_capture_ctrl
// Description : Sequencer for the fPIC (take-picture) instruction. On a
//               picture request it stalls the pipeline, takes ownership of
//               the single data-memory write port, waits for the next camera
//               frame start, streams FRAME_PIXELS pixels to consecutive
//               addresses from a latched base, then returns the port.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   ADDR_W        data-memory address width
//   PIX_W         pixel / write-data width
//   FRAME_PIXELS  pixels per captured frame (>= 1, < 2^ADDR_W)
//   TIMEOUT_CYC   max WAIT_FRAME cycles (only with CAPTURE_TIMEOUT_EN)
// Optional feature macro
//   CAPTURE_TIMEOUT_EN  when defined, WAIT_FRAME gives up after TIMEOUT_CYC
//                       cycles and finishes with err=1 and no writes. When
//                       undefined, err is tied to 0 and no counter exists.
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   pic_req, base_addr              picture request pulse and frame base
//   cam_frame_start                 camera vsync pulse
//   cam_pix_valid/data/ready        camera pixel stream handshake
//   cpu_mem_we/addr/wdata           pipeline memory-stage write request
//   mem_we/addr/wdata               data-memory write port
//   stall, busy, done, err          pipeline freeze and status
//   pix_count                       pixels written in current/last capture
// ============================================================================
module pic_capture_ctrl #(
    parameter int ADDR_W       = 16,
    parameter int PIX_W        = 8,
    parameter int FRAME_PIXELS = 4096,
    parameter int TIMEOUT_CYC  = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pic_req,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              cam_frame_start,
    input  logic              cam_pix_valid,
    input  logic [PIX_W-1:0]  cam_pix_data,
    output logic              cam_pix_ready,
    input  logic              cpu_mem_we,
    input  logic [ADDR_W-1:0] cpu_mem_addr,
    input  logic [PIX_W-1:0]  cpu_mem_wdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PIX_W-1:0]  mem_wdata,
    output logic              stall,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] pix_count
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_FRAME = 2'd1,
        ST_CAPTURE    = 2'd2,
        ST_DONE       = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] FRAME_CNT = ADDR_W'(FRAME_PIXELS);
    localparam logic [ADDR_W-1:0] CNT_ONE   = ADDR_W'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] pix_count_q, pix_count_d;
    logic              wr_we_q, wr_we_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [PIX_W-1:0]  wr_data_q, wr_data_d;

    logic              timeout_hit;
    logic              beat;
    logic [ADDR_W-1:0] cnt_base;
    logic [ADDR_W-1:0] cnt_next;

`ifdef CAPTURE_TIMEOUT_EN
    localparam int                TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [TMO_W-1:0]  TMO_ONE  = TMO_W'(1);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;

    // A frame start on the final waiting cycle still wins over the timeout.
    assign timeout_hit = (state_q == ST_WAIT_FRAME) && !cam_frame_start &&
                         (tmo_q == TMO_LAST);

    always_comb begin
        tmo_d = tmo_q;
        err_d = err_q;
        if (state_q == ST_IDLE) begin
            tmo_d = '0;
            if (pic_req) begin
                err_d = 1'b0;
            end
        end else if (state_q == ST_WAIT_FRAME) begin
            tmo_d = tmo_q + TMO_ONE;
            if (timeout_hit) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    // A frame start during capture restarts the frame; a pixel accepted in
    // the same cycle becomes pixel 0 of the new frame.
    assign cnt_base = cam_frame_start ? '0 : pix_count_q;
    assign cnt_next = cnt_base + CNT_ONE;
    assign beat     = (state_q == ST_CAPTURE) && cam_pix_valid;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        pix_count_d = pix_count_q;
        wr_we_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;

        case (state_q)
            ST_IDLE: begin
                if (pic_req) begin
                    base_d      = base_addr;
                    pix_count_d = '0;
                    state_d     = ST_WAIT_FRAME;
                end
            end
            ST_WAIT_FRAME: begin
                if (cam_frame_start) begin
                    pix_count_d = '0;
                    state_d     = ST_CAPTURE;
                end else if (timeout_hit) begin
                    state_d = ST_DONE;
                end
            end
            ST_CAPTURE: begin
                if (beat) begin
                    wr_we_d     = 1'b1;
                    wr_addr_d   = base_q + cnt_base;   // wraps modulo 2^ADDR_W
                    wr_data_d   = cam_pix_data;
                    pix_count_d = cnt_next;
                    if (cnt_next == FRAME_CNT) begin
                        state_d = ST_DONE;
                    end
                end else if (cam_frame_start) begin
                    pix_count_d = '0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            pix_count_q <= '0;
            wr_we_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            pix_count_q <= pix_count_d;
            wr_we_q     <= wr_we_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    // Outside IDLE the capture write register owns the memory port, so the
    // last pixel write lands in the DONE cycle and CPU writes are dropped.
    always_comb begin
        if (state_q == ST_IDLE) begin
            mem_we    = cpu_mem_we;
            mem_addr  = cpu_mem_addr;
            mem_wdata = cpu_mem_wdata;
        end else begin
            mem_we    = wr_we_q;
            mem_addr  = wr_addr_q;
            mem_wdata = wr_data_q;
        end
    end

    assign cam_pix_ready = (state_q == ST_CAPTURE);
    assign busy          = (state_q != ST_IDLE);
    assign stall         = busy || pic_req;
    assign done          = (state_q == ST_DONE);
    assign pix_count     = pix_count_q;

endmodule
`default_nettype wire

// File: tb/tb_pic_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pic_capture_ctrl
// Description : Scoreboard bench for pic_capture_ctrl. Stimulus tasks model
//               each capture as "the k-th accepted pixel of the frame goes to
//               base + k" and queue the expected memory writes; a monitor
//               pops and compares every write seen on the memory port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pic_capture_ctrl;

    localparam int ADDR_W       = 16;
    localparam int PIX_W        = 8;
    localparam int FRAME_PIXELS = 4;
    localparam int TIMEOUT_CYC  = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              pic_req;
    logic [ADDR_W-1:0] base_addr;
    logic              cam_frame_start;
    logic              cam_pix_valid;
    logic [PIX_W-1:0]  cam_pix_data;
    logic              cam_pix_ready;
    logic              cpu_mem_we;
    logic [ADDR_W-1:0] cpu_mem_addr;
    logic [PIX_W-1:0]  cpu_mem_wdata;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [PIX_W-1:0]  mem_wdata;
    logic              stall, busy, done, err;
    logic [ADDR_W-1:0] pix_count;

    always #5 clk = ~clk;

    pic_capture_ctrl #(
        .ADDR_W(ADDR_W), .PIX_W(PIX_W),
        .FRAME_PIXELS(FRAME_PIXELS), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pic_req(pic_req), .base_addr(base_addr),
        .cam_frame_start(cam_frame_start), .cam_pix_valid(cam_pix_valid),
        .cam_pix_data(cam_pix_data), .cam_pix_ready(cam_pix_ready),
        .cpu_mem_we(cpu_mem_we), .cpu_mem_addr(cpu_mem_addr),
        .cpu_mem_wdata(cpu_mem_wdata), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .stall(stall), .busy(busy), .done(done),
        .err(err), .pix_count(pix_count)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [PIX_W-1:0]  data;
    } wr_t;

    wr_t exp_q[$];
    int  n_total = 0;
    int  n_bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_total++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
        end
    endtask

    // Monitor: every write visible on the memory port must be the next one
    // the stimulus predicted.
    initial begin : monitor
        wr_t e;
        forever begin
            @(negedge clk);
            if (rst_n && mem_we !== 1'b0) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    n_bad++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, want no write",
                             mem_addr, mem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("mem_write", {16'h0, mem_addr, mem_wdata}, {16'h0, e.addr, e.data});
                end
            end
        end
    end

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic to_sample();
        @(negedge clk);
    endtask

    task automatic clear_in();
        pic_req         = 1'b0;
        base_addr       = ADDR_W'($urandom);
        cam_frame_start = 1'b0;
        cam_pix_valid   = 1'b0;
        cam_pix_data    = PIX_W'($urandom);
        cpu_mem_we      = 1'b0;
        cpu_mem_addr    = ADDR_W'($urandom);
        cpu_mem_wdata   = PIX_W'($urandom);
    endtask

    // CPU write attempt while the controller owns the port: must be dropped.
    task automatic cpu_noise();
        cpu_mem_we    = ($urandom_range(0, 1) == 1);
        cpu_mem_addr  = 16'h0020;
        cpu_mem_wdata = PIX_W'($urandom);
    endtask

    task automatic idle_traffic(input int n);
        wr_t w;
        for (int i = 0; i < n; i++) begin
            to_drive();
            clear_in();
            cpu_mem_we      = (i == 0) || ($urandom_range(0, 1) == 1);
            cpu_mem_addr    = (i == 0) ? 16'h0020 : ADDR_W'($urandom);
            cam_frame_start = ($urandom_range(0, 3) == 0);
            cam_pix_valid   = ($urandom_range(0, 1) == 1);
            if (cpu_mem_we) begin
                w.addr = cpu_mem_addr;
                w.data = cpu_mem_wdata;
                exp_q.push_back(w);
            end
            to_sample();
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_stall", 32'(stall), 32'd0);
        end
    endtask

    // Request cycle plus a few WAIT_FRAME cycles with dropped pixels.
    task automatic start_req(input logic [ADDR_W-1:0] base, input bit same_start);
        int w;
        to_drive();
        clear_in();
        pic_req         = 1'b1;
        base_addr       = base;
        cam_frame_start = same_start;
        to_sample();
        check("stall_req", 32'(stall), 32'd1);
        check("busy_req", 32'(busy), 32'd0);
        w = $urandom_range(1, 3);
        for (int i = 0; i < w; i++) begin
            to_drive();
            clear_in();
            cam_pix_valid = ($urandom_range(0, 1) == 1);
            cpu_noise();
            to_sample();
            check("wait_ready", 32'(cam_pix_ready), 32'd0);
            check("wait_stall", 32'(stall), 32'd1);
            check("wait_err", 32'(err), 32'd0);
        end
        to_drive();
        clear_in();
        cam_frame_start = 1'b1;
        cpu_noise();
        to_sample();
        check("start_ready", 32'(cam_pix_ready), 32'd0);
    endtask

    // One full capture. pat (MSB first) fixes valid for the first 7 cycles
    // when use_pat is set; otherwise valid is random.
    task automatic capture(input logic [ADDR_W-1:0] base, input int resync_at,
                           input bit extra_req, input bit same_start,
                           input logic [6:0] pat, input bit use_pat,
                           input bit fixed_data);
        int  idx, prev, cyc;
        bit  resynced;
        wr_t w;
        start_req(base, same_start);
        idx      = 0;
        cyc      = 0;
        resynced = 0;
        while (idx < FRAME_PIXELS) begin
            to_drive();
            clear_in();
            cpu_noise();
            if (extra_req && cyc == 1) begin
                pic_req   = 1'b1;
                base_addr = 16'h5A5A;
            end
            if (use_pat && cyc < 7) cam_pix_valid = pat[6-cyc];
            else                    cam_pix_valid = ($urandom_range(0, 2) != 0);
            if (fixed_data) cam_pix_data = PIX_W'(8'h11 * (idx + 1));
            prev = idx;
            if (resync_at >= 0 && !resynced && idx == resync_at) begin
                cam_frame_start = 1'b1;
                cam_pix_valid   = 1'b1;
                resynced        = 1;
                idx             = 0;
            end
            if (cam_pix_valid) begin
                w.addr = base + ADDR_W'(idx);
                w.data = cam_pix_data;
                exp_q.push_back(w);
                idx++;
            end
            to_sample();
            check("cap_ready", 32'(cam_pix_ready), 32'd1);
            check("cap_count", 32'(pix_count), 32'(prev));
            check("cap_done", 32'(done), 32'd0);
            cyc++;
            if (cyc > 200) begin
                n_total++;
                n_bad++;
                $display("FAIL cap_budget: got %0d cycles, want <= 200", cyc);
                break;
            end
        end
        to_drive();
        clear_in();
        to_sample();
        check("done_pulse", 32'(done), 32'd1);
        check("done_stall", 32'(stall), 32'd1);
        check("done_count", 32'(pix_count), 32'(FRAME_PIXELS));
        check("done_err", 32'(err), 32'd0);
        to_drive();
        clear_in();
        to_sample();
        check("post_done", 32'(done), 32'd0);
        check("post_stall", 32'(stall), 32'd0);
        check("post_busy", 32'(busy), 32'd0);
        check("post_count", 32'(pix_count), 32'(FRAME_PIXELS));
    endtask

    initial begin : stimulus
        wr_t w;
        clear_in();
        cpu_mem_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            to_sample();
            check("rst_stall", 32'(stall), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_err", 32'(err), 32'd0);
            check("rst_ready", 32'(cam_pix_ready), 32'd0);
            check("rst_count", 32'(pix_count), 32'd0);
            check("rst_mem_we", 32'(mem_we), 32'd0);
        end
        to_drive();
        rst_n = 1'b1;

        idle_traffic(4);
        capture(16'h0100, -1, 0, 0, 7'b1111111, 1, 1);      // basic
        capture(ADDR_W'($urandom), -1, 0, 0, 7'b1001101, 1, 0); // gapped
        capture(16'hFFFE, -1, 0, 0, 7'b1111111, 1, 0);      // wrap
        capture(16'hFFFE, 2, 0, 0, 7'b1111111, 1, 0);       // resync after 2
        capture(ADDR_W'($urandom), -1, 1, 1, 7'b0, 0, 0);   // arbitration
        idle_traffic(3);

`ifdef CAPTURE_TIMEOUT_EN
        to_drive();
        clear_in();
        pic_req = 1'b1;
        to_sample();
        for (int k = 1; k <= TIMEOUT_CYC; k++) begin
            to_drive();
            clear_in();
            cam_pix_valid = ($urandom_range(0, 1) == 1);
            cpu_noise();
            to_sample();
            check("tmo_wait_done", 32'(done), 32'd0);
        end
        to_drive();
        clear_in();
        to_sample();
        check("tmo_done", 32'(done), 32'd1);
        check("tmo_err", 32'(err), 32'd1);
        to_drive();
        clear_in();
        to_sample();
        check("tmo_err_sticky", 32'(err), 32'd1);
        check("tmo_idle", 32'(busy), 32'd0);
        capture(ADDR_W'($urandom), -1, 0, 0, 7'b0, 0, 0);
`endif

        // Reset after two of four pixels.
        start_req(16'h0400, 0);
        for (int i = 0; i < 2; i++) begin
            to_drive();
            clear_in();
            cam_pix_valid = 1'b1;
            w.addr = 16'h0400 + ADDR_W'(i);
            w.data = cam_pix_data;
            exp_q.push_back(w);
        end
        to_drive();
        clear_in();
        to_sample();
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_stall", 32'(stall), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_mem_we", 32'(mem_we), 32'd0);
        check("arst_ready", 32'(cam_pix_ready), 32'd0);
        to_drive();
        to_drive();
        rst_n = 1'b1;
        capture(ADDR_W'($urandom), -1, 0, 0, 7'b0, 0, 0);

        for (int r = 0; r < 6; r++) begin
            idle_traffic($urandom_range(1, 3));
            capture(ADDR_W'($urandom),
                    ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, FRAME_PIXELS - 1)) : -1,
                    ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
                    7'b0, 0, 0);
        end

        to_drive();
        clear_in();
        to_drive();
        to_sample();
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
